// File: rtl/rib_i2c_master.sv
// rib_i2c_master: single-byte I2C master mapped on rib slave 7.
// The CPU programs DEV, TXDATA and CLKDIV, then writes CTRL.start. The block
// runs START, address+R/W, ACK, one data byte, ACK/NACK and STOP on open-drain
// SCL/SDA enables, and raises a level interrupt (CTRL.ie & STATUS.done).
module rib_i2c_master #(
  parameter logic [15:0] CLKDIV_RST = 16'd249
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        scl_oe_o,
  output logic        sda_oe_o,
  input  logic        sda_i,
  output logic        int_sig_o
);

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_DEV    = 8'h08;
  localparam logic [7:0] OFF_TXDATA = 8'h0C;
  localparam logic [7:0] OFF_RXDATA = 8'h10;
  localparam logic [7:0] OFF_CLKDIV = 8'h14;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_ADDR     = 3'd2,
    ST_ADDR_ACK = 3'd3,
    ST_DATA     = 3'd4,
    ST_DATA_ACK = 3'd5,
    ST_STOP     = 3'd6
  } state_t;

  // Line pattern for a given phase: returns {scl_oe, sda_oe} (1 = pull low).
  // Bit cells hold SCL low in q0/q3 and release it in q1/q2, so SDA only
  // changes while SCL is low; START and STOP move SDA while SCL is high.
  function automatic logic [1:0] line_ctl(input state_t st, input logic [1:0] q,
                                          input logic tx_bit, input logic rd);
    logic scl_low;
    scl_low = (q == 2'd0) || (q == 2'd3);
    case (st)
      ST_IDLE: line_ctl = 2'b00;
      ST_START: begin
        case (q)
          2'd0:    line_ctl = 2'b00;
          2'd1:    line_ctl = 2'b01;
          2'd2:    line_ctl = 2'b01;
          default: line_ctl = 2'b11;
        endcase
      end
      ST_ADDR:     line_ctl = {scl_low, ~tx_bit};
      ST_DATA:     line_ctl = {scl_low, (rd ? 1'b0 : ~tx_bit)};
      ST_ADDR_ACK: line_ctl = {scl_low, 1'b0};
      ST_DATA_ACK: line_ctl = {scl_low, 1'b0};
      ST_STOP: begin
        case (q)
          2'd0:    line_ctl = 2'b11;
          2'd1:    line_ctl = 2'b01;
          default: line_ctl = 2'b00;
        endcase
      end
      default: line_ctl = 2'b00;
    endcase
  endfunction

  // Architectural registers
  logic        r_ie;
  logic        r_rw;
  logic        r_busy;
  logic        r_done;
  logic        r_nack;
  logic [6:0]  r_dev;
  logic [7:0]  r_txdata;
  logic [7:0]  r_rxdata;
  logic [15:0] r_clkdiv;

  // Engine registers
  state_t      r_state;
  logic [15:0] r_cnt;
  logic [1:0]  r_q;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic        r_scl_oe;
  logic        r_sda_oe;
  logic        r_int;

  // Next-state values
  state_t      w_state_nx;
  logic [15:0] w_cnt_nx;
  logic [1:0]  w_q_nx;
  logic [2:0]  w_bit_nx;
  logic [7:0]  w_shift_nx;
  logic        w_done_nx;
  logic        w_nack_nx;
  logic [7:0]  w_rx_nx;
  logic        w_ie_nx;
  logic [1:0]  w_lines_nx;

  // Decoded bus events and timer ticks
  logic        w_cfg_ok;
  logic        w_wr_ctrl;
  logic        w_start;
  logic        w_clr_done;
  logic        w_tick;
  logic        w_q1_end;
  logic        w_q3_end;
  logic        w_unused;

  assign w_cfg_ok   = we_i && !r_busy;
  assign w_wr_ctrl  = w_cfg_ok && (addr_i[7:0] == OFF_CTRL);
  assign w_start    = w_wr_ctrl && data_i[0];
  assign w_clr_done = we_i && (addr_i[7:0] == OFF_STATUS) && data_i[1];
  assign w_tick     = (r_state != ST_IDLE) && (r_cnt == r_clkdiv);
  assign w_q1_end   = w_tick && (r_q == 2'd1);
  assign w_q3_end   = w_tick && (r_q == 2'd3);
  assign w_ie_nx    = w_wr_ctrl ? data_i[2] : r_ie;
  assign w_unused   = ^{addr_i[31:8], data_i[31:16]};

  // Next-state logic: phase timer, bit sequencing, shift path and status flags
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_q_nx     = r_q;
    w_bit_nx   = r_bit;
    w_shift_nx = r_shift;
    w_done_nx  = r_done;
    w_nack_nx  = r_nack;
    w_rx_nx    = r_rxdata;

    // Quarter-phase timer only runs while a transfer is in flight.
    if (r_state == ST_IDLE) begin
      w_cnt_nx = 16'd0;
      w_q_nx   = 2'd0;
    end else if (w_tick) begin
      w_cnt_nx = 16'd0;
      w_q_nx   = r_q + 2'd1;
    end else begin
      w_cnt_nx = r_cnt + 16'd1;
    end

    // W1C first, so a completing STOP in the same cycle still sets done.
    if (w_clr_done) begin
      w_done_nx = 1'b0;
    end else begin
      w_done_nx = r_done;
    end

    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_nx = ST_START;
          w_shift_nx = {r_dev, data_i[1]};
          w_done_nx  = 1'b0;
          w_nack_nx  = 1'b0;
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_START: begin
        if (w_q3_end) begin
          w_state_nx = ST_ADDR;
          w_bit_nx   = 3'd7;
        end else begin
          w_state_nx = ST_START;
        end
      end
      ST_ADDR: begin
        if (w_q3_end) begin
          w_shift_nx = {r_shift[6:0], 1'b0};
          if (r_bit == 3'd0) begin
            w_state_nx = ST_ADDR_ACK;
          end else begin
            w_bit_nx = r_bit - 3'd1;
          end
        end else begin
          w_state_nx = ST_ADDR;
        end
      end
      ST_ADDR_ACK: begin
        if (w_q1_end && sda_i) begin
          w_nack_nx = 1'b1;
        end else begin
          w_nack_nx = r_nack;
        end
        // An address NACK skips the data byte entirely.
        if (w_q3_end) begin
          if (r_nack) begin
            w_state_nx = ST_STOP;
          end else begin
            w_state_nx = ST_DATA;
            w_bit_nx   = 3'd7;
            w_shift_nx = r_txdata;
          end
        end else begin
          w_state_nx = ST_ADDR_ACK;
        end
      end
      ST_DATA: begin
        // Reads shift in on the tick ending q1 (SCL high); writes shift out at the cell end.
        if (r_rw && w_q1_end) begin
          w_shift_nx = {r_shift[6:0], sda_i};
        end else if (!r_rw && w_q3_end) begin
          w_shift_nx = {r_shift[6:0], 1'b0};
        end else begin
          w_shift_nx = r_shift;
        end
        if (w_q3_end) begin
          if (r_bit == 3'd0) begin
            w_state_nx = ST_DATA_ACK;
          end else begin
            w_bit_nx = r_bit - 3'd1;
          end
        end else begin
          w_state_nx = ST_DATA;
        end
      end
      ST_DATA_ACK: begin
        if (w_q1_end && !r_rw && sda_i) begin
          w_nack_nx = 1'b1;
        end else begin
          w_nack_nx = r_nack;
        end
        if (w_q3_end) begin
          w_state_nx = ST_STOP;
          if (r_rw) begin
            w_rx_nx = r_shift;
          end else begin
            w_rx_nx = r_rxdata;
          end
        end else begin
          w_state_nx = ST_DATA_ACK;
        end
      end
      ST_STOP: begin
        if (w_q3_end) begin
          w_state_nx = ST_IDLE;
          w_done_nx  = 1'b1;
        end else begin
          w_state_nx = ST_STOP;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase

    // Outputs are registered from next-state values so the pins line up with the phase.
    w_lines_nx = line_ctl(w_state_nx, w_q_nx, w_shift_nx[7], r_rw);
  end

  // FSM state, timer, shift path, status flags and registered pin/interrupt outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 16'd0;
      r_q      <= 2'd0;
      r_bit    <= 3'd0;
      r_shift  <= 8'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_nack   <= 1'b0;
      r_rxdata <= 8'd0;
      r_scl_oe <= 1'b0;
      r_sda_oe <= 1'b0;
      r_int    <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_q      <= w_q_nx;
      r_bit    <= w_bit_nx;
      r_shift  <= w_shift_nx;
      r_busy   <= (w_state_nx != ST_IDLE);
      r_done   <= w_done_nx;
      r_nack   <= w_nack_nx;
      r_rxdata <= w_rx_nx;
      r_scl_oe <= w_lines_nx[1];
      r_sda_oe <= w_lines_nx[0];
      r_int    <= w_ie_nx & w_done_nx;
    end
  end

  // Configuration registers; frozen while a transfer is in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ie     <= 1'b0;
      r_rw     <= 1'b0;
      r_dev    <= 7'd0;
      r_txdata <= 8'd0;
      r_clkdiv <= CLKDIV_RST;
    end else begin
      if (w_wr_ctrl) begin
        r_ie <= data_i[2];
        r_rw <= data_i[1];
      end
      if (w_cfg_ok && (addr_i[7:0] == OFF_DEV)) begin
        r_dev <= data_i[6:0];
      end
      if (w_cfg_ok && (addr_i[7:0] == OFF_TXDATA)) begin
        r_txdata <= data_i[7:0];
      end
      if (w_cfg_ok && (addr_i[7:0] == OFF_CLKDIV)) begin
        r_clkdiv <= data_i[15:0];
      end
    end
  end

  // Combinational read mux; CTRL.start always reads back as 0
  always_comb begin
    data_o = 32'd0;
    case (addr_i[7:0])
      OFF_CTRL:   data_o = {29'd0, r_ie, r_rw, 1'b0};
      OFF_STATUS: data_o = {29'd0, r_nack, r_done, r_busy};
      OFF_DEV:    data_o = {25'd0, r_dev};
      OFF_TXDATA: data_o = {24'd0, r_txdata};
      OFF_RXDATA: data_o = {24'd0, r_rxdata};
      OFF_CLKDIV: data_o = {16'd0, r_clkdiv};
      default:    data_o = 32'd0;
    endcase
  end

  assign scl_oe_o  = r_scl_oe;
  assign sda_oe_o  = r_sda_oe;
  assign int_sig_o = r_int;

endmodule

// File: tb/tb_rib_i2c_master.sv
// Bench for rib_i2c_master: a behavioural I2C slave/bus monitor watches the
// open-drain lines, records every bit seen on an SCL rise and answers with
// ACK/NACK or read data. Expected bus traffic, durations and register values
// are derived from the transaction parameters.
module tb_rib_i2c_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        scl_oe_o;
  logic        sda_oe_o;
  logic        sda_i;
  logic        int_sig_o;

  int n_cmp  = 0;
  int n_fail = 0;

  // Slave / monitor state
  logic        slv_clear;
  logic        slv_ack;
  logic        slv_dack;
  logic [7:0]  slv_rd;
  logic        slv_pull;
  logic        slv_rd_mode;
  logic        prev_scl;
  logic        prev_sda;
  int          slv_n;
  logic [31:0] rec_vec;
  int          rec_n;
  int          start_cnt;
  int          stop_cnt;
  logic        scl_ln;
  logic        sda_ln;

  logic [7:0]  exp_rx;

  always #5 clk = ~clk;

  assign scl_ln = ~scl_oe_o;
  assign sda_ln = ~(sda_oe_o | slv_pull);
  assign sda_i  = sda_ln;

  rib_i2c_master dut (
    .clk       (clk),
    .rst       (rst),
    .we_i      (we_i),
    .addr_i    (addr_i),
    .data_i    (data_i),
    .data_o    (data_o),
    .scl_oe_o  (scl_oe_o),
    .sda_oe_o  (sda_oe_o),
    .sda_i     (sda_i),
    .int_sig_o (int_sig_o)
  );

  // I2C slave and bus monitor: START/STOP detection, bit capture on SCL rise, drive on SCL fall
  always @(posedge clk) begin
    if (slv_clear) begin
      prev_scl    <= 1'b1;
      prev_sda    <= 1'b1;
      slv_pull    <= 1'b0;
      slv_n       <= 0;
      slv_rd_mode <= 1'b0;
      rec_vec     <= 32'd0;
      rec_n       <= 0;
      start_cnt   <= 0;
      stop_cnt    <= 0;
    end else begin
      prev_scl <= scl_ln;
      prev_sda <= sda_ln;
      if (prev_scl && scl_ln && prev_sda && !sda_ln) begin
        start_cnt <= start_cnt + 1;
        slv_n     <= 0;
      end else if (prev_scl && scl_ln && !prev_sda && sda_ln) begin
        // The SCL rise inside STOP is not a data bit.
        stop_cnt <= stop_cnt + 1;
        rec_vec  <= rec_vec >> 1;
        rec_n    <= rec_n - 1;
        slv_pull <= 1'b0;
      end else if (!prev_scl && scl_ln) begin
        rec_vec <= {rec_vec[30:0], sda_ln};
        rec_n   <= rec_n + 1;
        if (slv_n == 7) slv_rd_mode <= sda_ln;
        slv_n <= slv_n + 1;
      end else if (prev_scl && !scl_ln) begin
        if (slv_n == 8)
          slv_pull <= slv_ack;
        else if (slv_ack && slv_rd_mode && slv_n >= 9 && slv_n <= 16)
          slv_pull <= ~slv_rd[16 - slv_n];
        else if (slv_ack && !slv_rd_mode && slv_n == 17)
          slv_pull <= slv_dack;
        else
          slv_pull <= 1'b0;
      end
    end
  end

  task automatic rib_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    we_i   = 1'b1;
    addr_i = {24'd0, a};
    data_i = d;
    @(posedge clk);
    #1;
    we_i   = 1'b0;
    data_i = 32'd0;
  endtask

  task automatic rib_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    we_i   = 1'b0;
    addr_i = {24'd0, a};
    #1;
    d = data_o;
  endtask

  task automatic bus_clear();
    @(negedge clk);
    slv_clear = 1'b1;
    @(negedge clk);
    slv_clear = 1'b0;
  endtask

  // Reference bit stream seen on SCL rises for one transaction.
  task automatic model_bits(input logic [6:0] dev, input logic [7:0] tx, input logic rw,
                            input logic ack, input logic dack, input logic [7:0] rd,
                            output logic [31:0] v, output int n);
    logic [7:0] ab;
    ab = {dev, rw};
    v  = 32'd0;
    n  = 0;
    for (int i = 7; i >= 0; i--) begin v = {v[30:0], ab[i]}; n++; end
    v = {v[30:0], ~ack}; n++;
    if (ack) begin
      for (int i = 7; i >= 0; i--) begin v = {v[30:0], (rw ? rd[i] : tx[i])}; n++; end
      v = {v[30:0], (rw ? 1'b1 : ~dack)}; n++;
    end
  endtask

  // Program and start a transaction, then count cycles until STATUS.done.
  task automatic do_txn(input logic [6:0] dev, input logic [7:0] tx, input logic rw,
                        input logic ie, input logic mid,
                        output int cyc, output logic int_prev, output logic int_done);
    logic got;
    bus_clear();
    rib_write(8'h08, {25'd0, dev});
    rib_write(8'h0C, {24'd0, tx});
    rib_write(8'h00, {29'd0, ie, rw, 1'b1});
    cyc = 0; got = 1'b0; int_prev = 1'b0; int_done = 1'b0;
    while (!got && cyc < 20000) begin
      @(negedge clk);
      if (mid && cyc == 30) begin
        we_i = 1'b1; addr_i = 32'h0000_0000; data_i = 32'h0000_0003;
      end else if (mid && cyc == 31) begin
        we_i = 1'b1; addr_i = 32'h0000_000C; data_i = 32'h0000_00FF;
      end else begin
        we_i = 1'b0; addr_i = 32'h0000_0004; data_i = 32'd0;
      end
      int_prev = int_sig_o;
      @(posedge clk);
      cyc++;
      #1;
      if (addr_i == 32'h0000_0004 && data_o[1] === 1'b1) begin
        got = 1'b1;
        int_done = int_sig_o;
      end
    end
    we_i = 1'b0;
    data_i = 32'd0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rib_read(8'h14, d);
    n_cmp++; if (d !== 32'h0000_00F9) begin n_fail++; $display("FAIL reset_clkdiv: got %h want %h", d, 32'h0000_00F9); end
    rib_read(8'h04, d);
    n_cmp++; if (d !== 32'd0) begin n_fail++; $display("FAIL reset_status: got %h want 0", d); end
    rib_read(8'h00, d);
    n_cmp++; if (d !== 32'd0) begin n_fail++; $display("FAIL reset_ctrl: got %h want 0", d); end
    rib_read(8'h10, d);
    n_cmp++; if (d !== 32'd0) begin n_fail++; $display("FAIL reset_rxdata: got %h want 0", d); end
    n_cmp++; if (scl_oe_o !== 1'b0) begin n_fail++; $display("FAIL reset_scl: got %b want 0", scl_oe_o); end
    n_cmp++; if (sda_oe_o !== 1'b0) begin n_fail++; $display("FAIL reset_sda: got %b want 0", sda_oe_o); end
    n_cmp++; if (int_sig_o !== 1'b0) begin n_fail++; $display("FAIL reset_int: got %b want 0", int_sig_o); end
  endtask

  task automatic test_write();
    int cyc, en; logic ip, id; logic [31:0] ev, d;
    rib_write(8'h14, 32'd1);
    slv_ack = 1'b1; slv_dack = 1'b1;
    do_txn(7'h50, 8'hA5, 1'b0, 1'b0, 1'b0, cyc, ip, id);
    model_bits(7'h50, 8'hA5, 1'b0, 1'b1, 1'b1, 8'h00, ev, en);
    n_cmp++; if (cyc != 160) begin n_fail++; $display("FAIL write_cycles: got %0d want 160", cyc); end
    n_cmp++; if (rec_vec !== ev || rec_n != en) begin n_fail++; $display("FAIL write_bits: got %h/%0d want %h/%0d", rec_vec, rec_n, ev, en); end
    n_cmp++; if (start_cnt != 1 || stop_cnt != 1) begin n_fail++; $display("FAIL write_startstop: got %0d/%0d want 1/1", start_cnt, stop_cnt); end
    rib_read(8'h04, d);
    n_cmp++; if (d !== 32'h2) begin n_fail++; $display("FAIL write_status: got %h want 2", d); end
    n_cmp++; if (scl_oe_o !== 1'b0 || sda_oe_o !== 1'b0) begin n_fail++; $display("FAIL write_idle_lines: got %b%b want 00", scl_oe_o, sda_oe_o); end
  endtask

  task automatic test_read();
    int cyc, en; logic ip, id; logic [31:0] ev, d;
    slv_ack = 1'b1; slv_dack = 1'b1; slv_rd = 8'h3C;
    do_txn(7'h50, 8'h00, 1'b1, 1'b0, 1'b0, cyc, ip, id);
    model_bits(7'h50, 8'h00, 1'b1, 1'b1, 1'b1, 8'h3C, ev, en);
    exp_rx = 8'h3C;
    n_cmp++; if (cyc != 160) begin n_fail++; $display("FAIL read_cycles: got %0d want 160", cyc); end
    n_cmp++; if (rec_vec !== ev || rec_n != en) begin n_fail++; $display("FAIL read_bits: got %h/%0d want %h/%0d", rec_vec, rec_n, ev, en); end
    rib_read(8'h10, d);
    n_cmp++; if (d !== {24'd0, exp_rx}) begin n_fail++; $display("FAIL read_rxdata: got %h want %h", d, exp_rx); end
    rib_read(8'h04, d);
    n_cmp++; if (d !== 32'h2) begin n_fail++; $display("FAIL read_status: got %h want 2", d); end
  endtask

  task automatic test_addr_nack();
    int cyc, en; logic ip, id; logic [31:0] ev, d;
    slv_ack = 1'b0; slv_dack = 1'b1;
    do_txn(7'h50, 8'h11, 1'b0, 1'b0, 1'b0, cyc, ip, id);
    model_bits(7'h50, 8'h11, 1'b0, 1'b0, 1'b1, 8'h00, ev, en);
    n_cmp++; if (cyc != 88) begin n_fail++; $display("FAIL nack_cycles: got %0d want 88", cyc); end
    n_cmp++; if (rec_vec !== ev || rec_n != en) begin n_fail++; $display("FAIL nack_bits: got %h/%0d want %h/%0d", rec_vec, rec_n, ev, en); end
    n_cmp++; if (stop_cnt != 1) begin n_fail++; $display("FAIL nack_stop: got %0d want 1", stop_cnt); end
    rib_read(8'h04, d);
    n_cmp++; if (d !== 32'h6) begin n_fail++; $display("FAIL nack_status: got %h want 6", d); end
    rib_read(8'h10, d);
    n_cmp++; if (d !== {24'd0, exp_rx}) begin n_fail++; $display("FAIL nack_rxdata: got %h want %h", d, exp_rx); end
  endtask

  task automatic test_busy_irq();
    int cyc, en; logic ip, id; logic [31:0] ev, d;
    slv_ack = 1'b1; slv_dack = 1'b1;
    do_txn(7'h50, 8'hA5, 1'b0, 1'b1, 1'b1, cyc, ip, id);
    model_bits(7'h50, 8'hA5, 1'b0, 1'b1, 1'b1, 8'h00, ev, en);
    n_cmp++; if (cyc != 160) begin n_fail++; $display("FAIL busy_cycles: got %0d want 160", cyc); end
    n_cmp++; if (rec_vec !== ev || rec_n != en) begin n_fail++; $display("FAIL busy_bits: got %h/%0d want %h/%0d", rec_vec, rec_n, ev, en); end
    n_cmp++; if (ip !== 1'b0) begin n_fail++; $display("FAIL irq_before_done: got %b want 0", ip); end
    n_cmp++; if (id !== 1'b1) begin n_fail++; $display("FAIL irq_at_done: got %b want 1", id); end
    rib_read(8'h0C, d);
    n_cmp++; if (d !== 32'hA5) begin n_fail++; $display("FAIL busy_txdata: got %h want a5", d); end
    rib_read(8'h00, d);
    n_cmp++; if (d !== 32'h4) begin n_fail++; $display("FAIL busy_ctrl: got %h want 4", d); end
    rib_write(8'h04, 32'h2);
    n_cmp++; if (int_sig_o !== 1'b0) begin n_fail++; $display("FAIL irq_clear: got %b want 0", int_sig_o); end
    rib_read(8'h04, d);
    n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL w1c_status: got %h want 0", d); end
    rib_write(8'h00, 32'h0);
  endtask

  task automatic test_reset_mid();
    int cyc, en; logic ip, id; logic [31:0] ev, d;
    slv_ack = 1'b1; slv_dack = 1'b1;
    bus_clear();
    rib_write(8'h14, 32'd1);
    rib_write(8'h08, 32'h50);
    rib_write(8'h0C, 32'hC3);
    rib_write(8'h00, 32'h1);
    repeat (100) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; slv_clear = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; slv_clear = 1'b0;
    exp_rx = 8'h00;
    n_cmp++; if (scl_oe_o !== 1'b0 || sda_oe_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_lines: got %b%b want 00", scl_oe_o, sda_oe_o); end
    rib_read(8'h04, d);
    n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL rstmid_status: got %h want 0", d); end
    rib_read(8'h14, d);
    n_cmp++; if (d !== 32'hF9) begin n_fail++; $display("FAIL rstmid_clkdiv: got %h want f9", d); end
    rib_write(8'h14, 32'd0);
    do_txn(7'h2B, 8'h96, 1'b0, 1'b0, 1'b0, cyc, ip, id);
    model_bits(7'h2B, 8'h96, 1'b0, 1'b1, 1'b1, 8'h00, ev, en);
    n_cmp++; if (cyc != 80) begin n_fail++; $display("FAIL rstmid_cycles: got %0d want 80", cyc); end
    n_cmp++; if (rec_vec !== ev || rec_n != en) begin n_fail++; $display("FAIL rstmid_bits: got %h/%0d want %h/%0d", rec_vec, rec_n, ev, en); end
  endtask

  task automatic test_random();
    int cyc, en, div, exp_cyc; logic ip, id, rw, ack, dack, exp_nack;
    logic [6:0] dev; logic [7:0] tx, rd; logic [31:0] ev, d;
    for (int it = 0; it < 8; it++) begin
      div  = $urandom_range(0, 3);
      dev  = 7'($urandom);
      tx   = 8'($urandom);
      rd   = 8'($urandom);
      rw   = 1'($urandom_range(0, 1));
      ack  = ($urandom_range(0, 3) != 0);
      dack = ($urandom_range(0, 3) != 0);
      slv_ack = ack; slv_dack = dack; slv_rd = rd;
      rib_write(8'h14, div);
      do_txn(dev, tx, rw, 1'b0, 1'b0, cyc, ip, id);
      model_bits(dev, tx, rw, ack, dack, rd, ev, en);
      exp_cyc  = (ack ? 80 : 44) * (div + 1);
      exp_nack = !ack || (!rw && !dack);
      if (rw && ack) exp_rx = rd;
      n_cmp++; if (cyc != exp_cyc) begin n_fail++; $display("FAIL rand%0d_cycles: got %0d want %0d", it, cyc, exp_cyc); end
      n_cmp++; if (rec_vec !== ev || rec_n != en) begin n_fail++; $display("FAIL rand%0d_bits: got %h/%0d want %h/%0d", it, rec_vec, rec_n, ev, en); end
      n_cmp++; if (stop_cnt != 1) begin n_fail++; $display("FAIL rand%0d_stop: got %0d want 1", it, stop_cnt); end
      rib_read(8'h04, d);
      n_cmp++; if (d !== {29'd0, exp_nack, 1'b1, 1'b0}) begin n_fail++; $display("FAIL rand%0d_status: got %h want %h", it, d, {29'd0, exp_nack, 1'b1, 1'b0}); end
      rib_read(8'h10, d);
      n_cmp++; if (d !== {24'd0, exp_rx}) begin n_fail++; $display("FAIL rand%0d_rxdata: got %h want %h", it, d, exp_rx); end
    end
  endtask

  initial begin
    rst = 1'b1; we_i = 1'b0; addr_i = 32'd0; data_i = 32'd0;
    slv_clear = 1'b1; slv_ack = 1'b1; slv_dack = 1'b1; slv_rd = 8'h00;
    exp_rx = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; slv_clear = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_addr_nack();
    test_busy_irq();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rib_i2c_master.md
Name: rib_i2c_master

Overview:
- Single-byte I2C master on rib slave 7 (0x7000_0000 region); fills the unused s7 slot of the SoC top.
- CPU programs device address, data and clock divider, then triggers one transaction: START, address+R/W, ACK, one data byte, ACK/NACK, STOP.
- Drives open-drain SCL/SDA enables; the SoC top converts them to tri-state pins. Raises a level interrupt on completion.

Parameters:
- CLKDIV_RST, 16'd249, reset value of CLKDIV register (quarter-bit period minus 1, in clk cycles).

Ports:
- clk  in  1  system clock; reset rst is synchronous, active-high.
- rst  in  1  synchronous reset, active-high.
- we_i  in  1  rib write strobe for this slave.
- addr_i  in  32  rib address; only addr_i[7:0] decoded.
- data_i  in  32  rib write data.
- data_o  out  32  rib read data, combinational from addr_i[7:0].
- scl_oe_o  out  1  1 = pull SCL low, 0 = release.
- sda_oe_o  out  1  1 = pull SDA low, 0 = release.
- sda_i  in  1  sampled SDA pin level.
- int_sig_o  out  1  CTRL.ie & STATUS.done.

Behaviour:
- Registers (word offsets): 0x00 CTRL [0] start (W, reads 0), [1] rw (0 write, 1 read), [2] ie. 0x04 STATUS (RO except W1C) [0] busy, [1] done (W1C), [2] nack. 0x08 DEV [6:0]. 0x0C TXDATA [7:0]. 0x10 RXDATA [7:0] RO. 0x14 CLKDIV [15:0]. Unmapped offsets read 0; writes ignored.
- Reset: all registers 0 except CLKDIV=CLKDIV_RST; FSM IDLE; scl_oe_o=0, sda_oe_o=0, int_sig_o=0.
- Writes while busy=1 to CTRL, DEV, TXDATA or CLKDIV are ignored. STATUS W1C is always accepted.
- CTRL write with start=1 in IDLE: latch rw and ie; next cycle busy=1; done and nack cleared; shift reg loaded {DEV,rw}; FSM enters START.
- Phase timer: counter 0..CLKDIV; tick when counter==CLKDIV, then counter wraps to 0. One bit = 4 quarter phases q0..q3, each CLKDIV+1 cycles.
- START: q0 SCL=rel, SDA=rel; q1–q2 SCL=rel, SDA=low; q3 SCL=low, SDA=low.
- Bit cell (ADDR, DATA, ACK): q0 SCL low, SDA set; q1–q2 SCL released; q3 SCL low. SDA is sampled on the tick ending q1.
- Bits are sent MSB first; a 3-bit counter runs 7 down to 0.
- ADDR: drive shift reg bits. ADDR_ACK: release SDA; sampled 1 sets nack=1 and the FSM goes to STOP (data skipped).
- DATA write (rw=0): drive TXDATA. DATA_ACK: release SDA; sampled 1 sets nack.
- DATA read (rw=1): release SDA, shift in sampled bits. DATA_ACK: master releases SDA (NACK). RXDATA is updated at the end of DATA_ACK.
- STOP: q0 SCL low, SDA low; q1 SCL rel, SDA low; q2–q3 SCL rel, SDA rel. On the tick ending q3: FSM=IDLE, busy=0, done=1 in the same cycle.
- Duration from busy rising to done: 80 phases (full) or 44 phases (address NACK), i.e. ×(CLKDIV+1) cycles.
- Simultaneous STOP completion and STATUS W1C of done in the same cycle: set wins (done=1).
- CLKDIV=0 is legal: 1-cycle phases.
- rst mid-transaction: next cycle IDLE, both lines released, registers at reset values. No STOP is generated.
- No clock stretching and no arbitration; SCL is never sampled.

Test Plan:
- Reset defaults: read 0x14 → 0x000000F9, 0x04 → 0, scl_oe_o=sda_oe_o=0 → pass.
- Write transaction: CLKDIV=1, DEV=0x50, TXDATA=0xA5, CTRL=0x1, bus model ACKs. Required: SDA bytes 0xA0 then 0xA5 on the SCL rising edges; done=1 exactly 160 cycles after busy rises; nack=0.
- Read transaction: DEV=0x50, CTRL=0x3, slave drives 0x3C. Required: address byte 0xA1; master releases SDA on the 9th data clock; RXDATA=0x3C; done=1.
- Address NACK: slave never ACKs. Required: nack=1, no data clocks, STOP issued, done after 88 cycles (CLKDIV=1).
- Busy protection and interrupt: second CTRL start and TXDATA=0xFF written mid-transfer are ignored (data stays 0xA5). With ie=1, int_sig_o rises with done; writing 0x2 to STATUS drops it next cycle.
- Reset mid-DATA: assert rst for 1 cycle. Required: lines released next cycle, busy=0, and a new transaction afterwards completes normally.
